// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target bridging byte transfers to a single-cycle register strobe bus
// Oversamples SCL/SDA on wb_clk_i, never stretches SCL, drives SDA open-drain through sda_oeb.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter int         REG_AW   = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oeb,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
  } state_t;

  state_t state, state_nx;

  logic scl_m, scl_s, scl_h;
  logic sda_m, sda_s, sda_h;
  logic scl_rise, scl_fall, start_c, stop_c;
  logic [2:0] bit_cnt;
  logic [6:0] sh;
  logic [7:0] tx;
  logic [7:0] rx_byte;
  logic       ack_phase;
  logic       rw;
  logic       rd_pend;
  logic       rd_cap;
  logic       byte_done;
  logic       addr_hit;
  logic       shifting;

  // Bus idles high, so synchronizers reset to 1 to avoid a phantom START.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      scl_m <= 1'b1; scl_s <= 1'b1; scl_h <= 1'b1;
      sda_m <= 1'b1; sda_s <= 1'b1; sda_h <= 1'b1;
    end else begin
      scl_m <= scl_i; scl_s <= scl_m; scl_h <= scl_s;
      sda_m <= sda_i; sda_s <= sda_m; sda_h <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_c   = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_c    = scl_s & scl_h & ~sda_h & sda_s;
  assign rx_byte   = {sh, sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);
  assign addr_hit  = (rx_byte[7:1] == I2C_ADDR);
  assign shifting  = (state == S_ADDR) || (state == S_PTR) ||
                     (state == S_WDATA) || (state == S_RDATA);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start_c) begin
      state_nx = S_ADDR;
    end else if (stop_c) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_ADDR:      if (byte_done) state_nx = addr_hit ? S_ADDR_ACK : S_WAIT;
        S_ADDR_ACK:  if (scl_fall && ack_phase) state_nx = rw ? S_RDATA : S_PTR;
        S_PTR:       if (byte_done) state_nx = S_PTR_ACK;
        S_PTR_ACK:   if (scl_fall && ack_phase) state_nx = S_WDATA;
        S_WDATA:     if (byte_done) state_nx = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall && ack_phase) state_nx = S_WDATA;
        S_RDATA:     if (byte_done) state_nx = S_RDATA_ACK;
        S_RDATA_ACK: begin
          if (scl_rise && ack_phase && sda_s) state_nx = S_WAIT;
          else if (scl_fall && ack_phase)     state_nx = S_RDATA;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sda_oeb   <= 1'b1;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= 3'd0;
      sh        <= 7'h00;
      tx        <= 8'hFF;
      ack_phase <= 1'b0;
      rw        <= 1'b0;
      rd_pend   <= 1'b0;
      rd_cap    <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      rd_pend   <= 1'b0;
      reg_rd_en <= rd_pend;
      rd_cap    <= reg_rd_en;
      if (rd_cap)    tx       <= reg_rdata;
      if (reg_wr_en) reg_addr <= reg_addr + REG_AW'(1);

      if (start_c || stop_c) begin
        bit_cnt   <= 3'd0;
        sda_oeb   <= 1'b1;
        busy      <= 1'b0;
        ack_phase <= 1'b0;
      end else begin
        if (scl_rise && shifting) begin
          sh      <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          S_ADDR: begin
            if (byte_done && addr_hit) begin
              busy <= 1'b1;
              rw   <= sda_s;
              if (sda_s) reg_rd_en <= 1'b1;
            end
          end
          S_PTR: if (byte_done) reg_addr <= REG_AW'(rx_byte);
          S_WDATA: begin
            if (byte_done) begin
              reg_wdata <= rx_byte;
              reg_wr_en <= 1'b1;
            end
          end
          // First fall after the byte drives ACK, second fall ends the slot.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oeb   <= 1'b0;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                sda_oeb   <= (state == S_ADDR_ACK && rw) ? tx[7] : 1'b1;
              end
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              sda_oeb <= tx[6];
              tx      <= {tx[6:0], 1'b1};
            end
          end
          S_RDATA_ACK: begin
            if (scl_fall && !ack_phase) begin
              sda_oeb   <= 1'b1;
              ack_phase <= 1'b1;
            end else if (scl_rise && ack_phase) begin
              if (sda_s) begin
                busy      <= 1'b0;
                ack_phase <= 1'b0;
              end else begin
                reg_addr <= reg_addr + REG_AW'(1);
                rd_pend  <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= 3'd0;
              sda_oeb   <= tx[7];
            end
          end
          default: sda_oeb <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed I2C controller model with write/read scoreboards
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oeb;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];

  assign sda_bus = sda_m & sda_oeb;
  always #5 clk = ~clk;

  i2c_target_regs #(.I2C_ADDR(7'h50), .REG_AW(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .scl_i    (scl),
    .sda_i    (sda_bus),
    .sda_oeb  (sda_oeb),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  // Register bank model: read data valid the cycle after the request.
  always @(posedge clk) if (reg_rd_en) reg_rdata <= reg_addr ^ 8'hFF;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_en) begin
        logic [15:0] exp;
        wr_cnt++;
        exp = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
        check("wr_strobe", {reg_addr, reg_wdata}, exp);
      end
      if (reg_rd_en) rd_cnt++;
      if (reg_wr_en || reg_rd_en) check("wr_rd_exclusive", {15'd0, reg_wr_en & reg_rd_en}, 16'd0);
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wclk(5);
    scl = 1'b1; wclk(10);
    scl = 1'b0; wclk(5);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wclk(5);
    scl = 1'b1; wclk(5);
    b = sda_bus; wclk(5);
    scl = 1'b0; wclk(5);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(5);
    scl = 1'b1; wclk(10);
    sda_m = 1'b0; wclk(10);
    scl = 1'b0; wclk(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(5);
    scl = 1'b1; wclk(10);
    sda_m = 1'b1; wclk(10);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         wr_base, rd_base;

    wclk(3);
    check("rst_sda_oeb", {15'd0, sda_oeb}, 16'd1);
    check("rst_reg_addr", {8'd0, reg_addr}, 16'h0000);
    check("rst_reg_wdata", {8'd0, reg_wdata}, 16'h0000);
    check("rst_wr_en", {15'd0, reg_wr_en}, 16'd0);
    check("rst_rd_en", {15'd0, reg_rd_en}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    wclk(5);

    // Write 0x55, 0xAA starting at pointer 0x10
    wr_q.push_back(16'h1055);
    wr_q.push_back(16'h11AA);
    i2c_start();
    send_byte(8'hA0, ack); check("wr_addr_ack", {15'd0, ack}, 16'd0);
    check("wr_busy", {15'd0, busy}, 16'd1);
    send_byte(8'h10, ack); check("wr_ptr_ack", {15'd0, ack}, 16'd0);
    send_byte(8'h55, ack); check("wr_d0_ack", {15'd0, ack}, 16'd0);
    send_byte(8'hAA, ack); check("wr_d1_ack", {15'd0, ack}, 16'd0);
    i2c_stop();
    wclk(5);
    check("wr_count", 16'(wr_cnt), 16'd2);
    check("wr_ptr_after", {8'd0, reg_addr}, 16'h0012);
    check("wr_busy_after_stop", {15'd0, busy}, 16'd0);

    // Pointer 0x20, repeated START, read three bytes
    rd_base = rd_cnt;
    i2c_start();
    send_byte(8'hA0, ack); check("rd_waddr_ack", {15'd0, ack}, 16'd0);
    send_byte(8'h20, ack); check("rd_ptr_ack", {15'd0, ack}, 16'd0);
    i2c_start();
    send_byte(8'hA1, ack); check("rd_raddr_ack", {15'd0, ack}, 16'd0);
    rd_q.push_back(8'hDF);
    rd_q.push_back(8'hDE);
    rd_q.push_back(8'hDD);
    for (int i = 0; i < 3; i++) begin
      recv_byte(rb);
      check("rd_byte", {8'd0, rb}, {8'd0, rd_q.pop_front()});
      send_bit(i == 2);
    end
    check("rd_released_after_nack", {15'd0, sda_oeb}, 16'd1);
    check("rd_busy_after_nack", {15'd0, busy}, 16'd0);
    check("rd_count", 16'(rd_cnt - rd_base), 16'd3);
    i2c_stop();
    wclk(5);

    // Foreign address: NACK and ignore data until STOP
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    i2c_start();
    send_byte(8'h42, ack); check("mis_addr_nack", {15'd0, ack}, 16'd1);
    check("mis_busy", {15'd0, busy}, 16'd0);
    send_byte(8'h99, ack); check("mis_data_nack", {15'd0, ack}, 16'd1);
    i2c_stop();
    wclk(5);
    check("mis_no_wr", 16'(wr_cnt - wr_base), 16'd0);
    check("mis_no_rd", 16'(rd_cnt - rd_base), 16'd0);

    // Pointer wrap from 0xFF to 0x00
    wr_base = wr_cnt;
    wr_q.push_back(16'hFF11);
    wr_q.push_back(16'h0022);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack); check("wrap_d0_ack", {15'd0, ack}, 16'd0);
    send_byte(8'h22, ack); check("wrap_d1_ack", {15'd0, ack}, 16'd0);
    i2c_stop();
    wclk(5);
    check("wrap_count", 16'(wr_cnt - wr_base), 16'd2);
    check("wrap_ptr_after", {8'd0, reg_addr}, 16'h0001);

    // STOP after four data bits discards the partial byte
    wr_base = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h30, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    wclk(5);
    check("abort_no_wr", 16'(wr_cnt - wr_base), 16'd0);
    check("abort_ptr", {8'd0, reg_addr}, 16'h0030);
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_sda_released", {15'd0, sda_oeb}, 16'd1);

    // Reset while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
    check("ack_driven", {15'd0, sda_oeb}, 16'd0);
    rst = 1'b1;
    #1;
    check("rst_ack_sda_oeb", {15'd0, sda_oeb}, 16'd1);
    check("rst_ack_reg_addr", {8'd0, reg_addr}, 16'h0000);
    check("rst_ack_reg_wdata", {8'd0, reg_wdata}, 16'h0000);
    check("rst_ack_busy", {15'd0, busy}, 16'd0);
    check("rst_ack_strobes", {14'd0, reg_wr_en, reg_rd_en}, 16'd0);
    wclk(2);
    rst = 1'b0;
    i2c_stop();
    wclk(5);
    check("wr_queue_drained", 16'(wr_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
